// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the EX stage (port 0)
// and the branch/address helper (port 1), returning results on a single response channel.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid0,
  input  logic                  i_req_valid1,
  output logic                  o_req_ready0,
  output logic                  o_req_ready1,
  input  logic [DATA_WIDTH-1:0] i_req_a0,
  input  logic [DATA_WIDTH-1:0] i_req_b0,
  input  logic [DATA_WIDTH-1:0] i_req_a1,
  input  logic [DATA_WIDTH-1:0] i_req_b1,
  input  logic [3:0]            i_req_ctl0,
  input  logic [3:0]            i_req_ctl1,
  input  logic [TAG_WIDTH-1:0]  i_req_tag0,
  input  logic [TAG_WIDTH-1:0]  i_req_tag1,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [3:0]            o_alu_control,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic                  o_resp_id,
  output logic [TAG_WIDTH-1:0]  o_resp_tag,
  output logic [DATA_WIDTH-1:0] o_resp_result,
  output logic                  o_resp_zero,
  output logic                  o_resp_err
);

  // state | meaning
  // IDLE  | waiting for a request; grant and accept happen here
  // EXEC  | ALU inputs driven from latched operands; result captured at the edge
  // RESP  | response presented until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [3:0]            r_alu_ctl;
  logic                  r_resp_id;
  logic [TAG_WIDTH-1:0]  r_resp_tag;
  logic [DATA_WIDTH-1:0] r_resp_result;
  logic                  r_resp_zero;
  logic                  r_resp_err;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic                  w_legal;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [3:0]            w_sel_ctl;
  logic [TAG_WIDTH-1:0]  w_sel_tag;

  function automatic logic is_legal(input logic [3:0] ctl);
    case (ctl)
      4'b0000, 4'b0110, 4'b0001, 4'b0010, 4'b1100: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  assign w_sel_a   = w_gnt1 ? i_req_a1   : i_req_a0;
  assign w_sel_b   = w_gnt1 ? i_req_b1   : i_req_b0;
  assign w_sel_ctl = w_gnt1 ? i_req_ctl1 : i_req_ctl0;
  assign w_sel_tag = w_gnt1 ? i_req_tag1 : i_req_tag0;
  assign w_legal   = is_legal(w_sel_ctl);
  assign w_accept  = w_gnt0 | w_gnt1;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are only issued in IDLE and never while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_reset_n) begin
          w_gnt0 = i_req_valid0 & (~i_req_valid1 | r_last_grant);
          w_gnt1 = i_req_valid1 & (~i_req_valid0 | ~r_last_grant);
        end
        if (w_gnt0 | w_gnt1) begin
          w_state_nxt = is_legal(w_gnt1 ? i_req_ctl1 : i_req_ctl0) ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (i_resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_last_grant  <= 1'b1;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctl     <= 4'b0000;
      r_resp_id     <= 1'b0;
      r_resp_tag    <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt1;
        r_resp_id    <= w_gnt1;
        r_resp_tag   <= w_sel_tag;
        if (w_legal) begin
          r_alu_a   <= w_sel_a;
          r_alu_b   <= w_sel_b;
          r_alu_ctl <= w_sel_ctl;
        end else begin
          // Rejected op skips the ALU entirely; its response is fixed.
          r_resp_err    <= 1'b1;
          r_resp_result <= '0;
          r_resp_zero   <= 1'b1;
        end
      end
      if (r_state == ST_EXEC) begin
        r_resp_result <= i_alu_result;
        r_resp_zero   <= (i_alu_result == '0);
        r_resp_err    <= 1'b0;
      end
    end
  end

  assign o_req_ready0  = w_gnt0;
  assign o_req_ready1  = w_gnt1;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_control = r_alu_ctl;
  assign o_resp_valid  = (r_state == ST_RESP);
  assign o_resp_id     = r_resp_id;
  assign o_resp_tag    = r_resp_tag;
  assign o_resp_result = r_resp_result;
  assign o_resp_zero   = r_resp_zero;
  assign o_resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single ops plus
// round-robin, back-pressure and mid-op reset sequences.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset_n;
  logic        v0, v1, rdy0, rdy1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  ctl0, ctl1, tag0, tag1;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctl;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [3:0]  resp_tag;
  logic [31:0] resp_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_alu_ctl;

  alu_share_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid0(v0), .i_req_valid1(v1),
    .o_req_ready0(rdy0), .o_req_ready1(rdy1),
    .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
    .i_req_ctl0(ctl0), .i_req_ctl1(ctl1),
    .i_req_tag0(tag0), .i_req_tag1(tag1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_control(alu_ctl),
    .i_alu_result(alu_res),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_id(resp_id), .o_resp_tag(resp_tag),
    .o_resp_result(resp_result), .o_resp_zero(resp_zero), .o_resp_err(resp_err)
  );

  // Reference ALU the arbiter drives.
  always_comb begin
    alu_res = 32'h0;
    case (alu_ctl)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0110: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a | alu_b;
      4'b0010: alu_res = alu_a & alu_b;
      4'b1100: alu_res = alu_a ^ alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        port;
    logic [31:0] a, b;
    logic [3:0]  ctl, tag;
    logic [31:0] res;
    logic        zero, err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctl, input logic [3:0] tag);
    if (port) begin
      a1 = a; b1 = b; ctl1 = ctl; tag1 = tag; v1 = 1'b1;
    end else begin
      a0 = a; b0 = b; ctl0 = ctl; tag0 = tag; v0 = 1'b1;
    end
  endtask

  // Entered and left on a negedge with the DUT idle and RespReady high.
  task automatic do_op(input vec_t v);
    v0 = 1'b0; v1 = 1'b0;
    set_req(v.port, v.a, v.b, v.ctl, v.tag);
    #1;
    check("vec_ready_win", v.port ? rdy1 : rdy0, 1'b1);
    check("vec_ready_lose", v.port ? rdy0 : rdy1, 1'b0);
    @(posedge clk); @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    if (!v.err) begin
      check("vec_exec_valid", resp_valid, 1'b0);
      check("vec_alu_ctl", alu_ctl, v.ctl);
      check("vec_alu_a", alu_a, v.a);
      check("vec_alu_b", alu_b, v.b);
      exp_alu_ctl = v.ctl;
      @(negedge clk);
    end else begin
      check("ill_alu_ctl_hold", alu_ctl, exp_alu_ctl);
    end
    check("vec_resp_valid", resp_valid, 1'b1);
    check("vec_result", resp_result, v.res);
    check("vec_zero", resp_zero, v.zero);
    check("vec_err", resp_err, v.err);
    check("vec_id", resp_id, v.port);
    check("vec_tag", resp_tag, v.tag);
    @(posedge clk); @(negedge clk);
    check("vec_resp_done", resp_valid, 1'b0);
  endtask

  initial begin
    int          cnt[2];
    logic [31:0] opa[2];
    logic        exp_port;

    vecs[0] = '{1'b0, 32'd5,        32'd7,        4'b0000, 4'd3,  32'd12,       1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h1234,     32'h1234,     4'b0110, 4'd5,  32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'd0,        32'd1,        4'b0110, 4'd6,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'hF0F00000, 32'h0F0F0000, 4'b0001, 4'd7,  32'hFFFF0000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0010, 4'd8,  32'h0F000F00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'hAAAA5555, 32'hFFFF0000, 4'b1100, 4'd9,  32'h55555555, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'd1,        32'd2,        4'b1111, 4'd10, 32'h0,        1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'd1,        4'b0000, 4'd11, 32'h0,        1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'd3,        32'd4,        4'b0011, 4'd12, 32'h0,        1'b1, 1'b1};

    reset_n = 1'b0; resp_ready = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 32'd1; b0 = 32'd1; ctl0 = 4'b0000; tag0 = 4'd0;
    a1 = 32'd2; b1 = 32'd2; ctl1 = 4'b0000; tag1 = 4'd0;
    exp_alu_ctl = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", rdy0, 1'b0);
    check("rst_ready1", rdy1, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_ctl", alu_ctl, 4'b0000);
    check("rst_resp_result", resp_result, 32'h0);
    check("rst_resp_tag", resp_tag, 4'h0);
    check("rst_resp_flags", {resp_id, resp_zero, resp_err}, 3'b000);

    // Round-robin under continuous dual requests, starting with port 0.
    reset_n = 1'b1;
    cnt[0] = 0; cnt[1] = 0;
    opa[0] = 32'h100; opa[1] = 32'h200;
    set_req(1'b0, opa[0], 32'd0, 4'b0000, 4'd0);
    set_req(1'b1, opa[1], 32'd0, 4'b0000, 4'd8);
    for (int i = 0; i < 6; i++) begin
      exp_port = i[0];
      #1;
      check("rr_ready0", rdy0, !exp_port);
      check("rr_ready1", rdy1, exp_port);
      @(posedge clk); @(negedge clk);
      @(negedge clk);
      check("rr_valid", resp_valid, 1'b1);
      check("rr_id", resp_id, exp_port);
      check("rr_tag", resp_tag, exp_port ? 4'd8 + 4'(cnt[1]) : 4'(cnt[0]));
      check("rr_result", resp_result, opa[exp_port] + 32'(cnt[exp_port]));
      @(posedge clk); @(negedge clk);
      cnt[exp_port]++;
      opa[exp_port] = opa[exp_port] + 32'h10;
      if (exp_port)
        set_req(1'b1, opa[1], 32'(cnt[1]), 4'b0000, 4'd8 + 4'(cnt[1]));
      else
        set_req(1'b0, opa[0], 32'(cnt[0]), 4'b0000, 4'(cnt[0]));
    end
    v0 = 1'b0; v1 = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Back-pressure: response must hold and no request may be accepted.
    resp_ready = 1'b0;
    set_req(1'b0, 32'd20, 32'd22, 4'b0000, 4'd2);
    set_req(1'b1, 32'd30, 32'd3, 4'b0000, 4'd13);
    #1;
    check("bp_ready0", rdy0, 1'b1);
    @(posedge clk); @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    check("bp_valid", resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", resp_valid, 1'b1);
      check("bp_hold_result", resp_result, 32'd42);
      check("bp_hold_tag_id", {resp_tag, resp_id, resp_zero, resp_err}, {4'd2, 3'b000});
      check("bp_hold_ready", {rdy0, rdy1}, 2'b00);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    check("bp_next_valid", resp_valid, 1'b0);
    check("bp_next_ready1", rdy1, 1'b1);
    @(posedge clk); @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    check("bp_next_result", resp_result, 32'd33);
    check("bp_next_id", resp_id, 1'b1);
    @(posedge clk); @(negedge clk);

    // Mid-op reset during EXEC of a port-0 op.
    set_req(1'b0, 32'd9, 32'd9, 4'b0000, 4'd1);
    @(posedge clk); @(negedge clk);
    check("mr_in_exec", alu_a, 32'd9);
    reset_n = 1'b0;
    set_req(1'b1, 32'd50, 32'd5, 4'b0000, 4'd14);
    set_req(1'b0, 32'd7, 32'd8, 4'b0000, 4'd4);
    @(posedge clk); @(negedge clk);
    check("mr_valid", resp_valid, 1'b0);
    check("mr_ready", {rdy0, rdy1}, 2'b00);
    reset_n = 1'b1;
    #1;
    check("mr_tie_ready0", rdy0, 1'b1);
    check("mr_tie_ready1", rdy1, 1'b0);
    @(posedge clk); @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    check("mr_no_stale", resp_valid, 1'b0);
    @(negedge clk);
    check("mr_resp_valid", resp_valid, 1'b1);
    check("mr_resp_id", resp_id, 1'b0);
    check("mr_resp_tag", resp_tag, 4'd4);
    check("mr_resp_result", resp_result, 32'd15);
    @(posedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
